gray_counter: RTL and testbench

//   Synchronous up/down Gray-code counter; the stage directly upstream of the gray_bin converter.

---
 rtl/gray_pkg.sv | 34 +++
 rtl/gray_bin.sv | 14 +
 rtl/gray_counter.sv | 120 ++++++++++++
 tb/tb_gray_counter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers for the Gray counter and its converters.
// Functions operate on a 32-bit container; narrower codes are zero-extended by the caller.
package gray_pkg;

  localparam int unsigned FN_W      = 32;
  localparam int unsigned DEF_WIDTH = 4;
  localparam logic [DEF_WIDTH-1:0] CNT_MAX = {DEF_WIDTH{1'b1}};

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result width-independent.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b = g;
    for (int i = 1; i < FN_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned hamming(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b);
    logic [FN_W-1:0] d;
    int unsigned     n;
    d = a ^ b;
    n = 0;
    for (int i = 0; i < FN_W; i++) begin
      n = n + 32'(d[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_bin.sv
// Existing 4-bit Gray to binary converter, purely combinational.
module gray_bin (
  input  logic [3:0] gray,
  output logic [3:0] bin_c
);

  always_comb begin
    bin_c[3] = gray[3];
    bin_c[2] = gray[3] ^ gray[2];
    bin_c[1] = gray[3] ^ gray[2] ^ gray[1];
    bin_c[0] = gray[3] ^ gray[2] ^ gray[1] ^ gray[0];
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down Gray counter with parallel load, wrap/saturate ends and terminal-count pulse.
// Optional Hamming-distance checker on gray_out enabled by GRAY_CNT_CHK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter bit               WRAP     = 1'b1,
  parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc
`ifdef GRAY_CNT_CHK_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(gray2bin(32'(RST_GRAY)));

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] load_bin;
  logic             step;
  logic             tc_d;
  logic             tc_q;

  // The 4-bit case reuses the existing converter; other widths use the package function.
  generate
    if (WIDTH == 4) begin : g_conv4
      gray_bin u_gray_bin (
        .gray  (load_gray),
        .bin_c (load_bin)
      );
    end else begin : g_convn
      assign load_bin = WIDTH'(gray2bin(32'(load_gray)));
    end
  endgenerate

  // Next count; step marks a real move, so a saturated hold never re-pulses tc.
  always_comb begin
    bin_d = bin_q;
    step  = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (bin_q != MAX_VAL) begin
          bin_d = bin_q + WIDTH'(1);
          step  = 1'b1;
        end else if (WRAP) begin
          bin_d = '0;
          step  = 1'b1;
        end
      end else begin
        if (bin_q != '0) begin
          bin_d = bin_q - WIDTH'(1);
          step  = 1'b1;
        end else if (WRAP) begin
          bin_d = MAX_VAL;
          step  = 1'b1;
        end
      end
    end
    tc_d = step && ((up_dn && (bin_d == MAX_VAL)) || (!up_dn && (bin_d == '0)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
    end else begin
      bin_q  <= bin_d;
      gray_q <= WIDTH'(bin2gray(32'(bin_d)));
    end
  end

`ifdef GRAY_CNT_CHK_EN
  logic [WIDTH-1:0] shadow_q;
  logic             chk_q;
  logic             err_q;
`endif

  // chk_q flags that the latest gray_q update came from a count/hold, not a load or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q     <= 1'b0;
`ifdef GRAY_CNT_CHK_EN
      shadow_q <= RST_GRAY;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      tc_q     <= tc_d;
`ifdef GRAY_CNT_CHK_EN
      shadow_q <= gray_q;
      chk_q    <= !load;
      if (chk_q && (hamming(32'(shadow_q), 32'(gray_q)) > 32'd1)) begin
        err_q <= 1'b1;
      end
`endif
    end
  end

  assign gray_out = gray_q;
  assign bin_out  = bin_q;
  assign tc       = tc_q;
`ifdef GRAY_CNT_CHK_EN
  assign err      = err_q;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share stimulus and are
// checked against an index-based model built on a reflected Gray-code table.
module tb_gray_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_gray;
  logic [W-1:0] gw, bw, gs, bs;
  logic         tw, ts;
`ifdef GRAY_CNT_CHK_EN
  logic         err_w, err_s;
`endif

  int total = 0;
  int bad   = 0;
  int gtab[16];
  int mv_w, mv_s;
  bit mt_w, mt_s;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .WRAP(1'b1), .RST_GRAY(4'b0000)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray_out(gw), .bin_out(bw), .tc(tw)
`ifdef GRAY_CNT_CHK_EN
    , .err(err_w)
`endif
  );

  gray_counter #(.WIDTH(W), .WRAP(1'b0), .RST_GRAY(4'b0011)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray_out(gs), .bin_out(bs), .tc(ts)
`ifdef GRAY_CNT_CHK_EN
    , .err(err_s)
`endif
  );

  function automatic int gray_idx(input int g);
    for (int i = 0; i < 16; i++) begin
      if (gtab[i] == g) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: position in the Gray sequence, moved by the counting rules.
  task automatic mstep(input bit wrap, input int rst_idx, inout int v, output bit t);
    t = 1'b0;
    if (!rst_n) v = rst_idx;
    else if (load) v = gray_idx(int'(load_gray));
    else if (en) begin
      if (up_dn) begin
        if (v < 15) begin v++; t = (v == 15); end
        else if (wrap) v = 0;
      end else begin
        if (v > 0) begin v--; t = (v == 0); end
        else if (wrap) v = 15;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input logic [W-1:0] lg);
    rst_n = r; en = e; up_dn = u; load = l; load_gray = lg;
    @(posedge clk);
    mstep(1'b1, 0, mv_w, mt_w);
    mstep(1'b0, 2, mv_s, mt_s);
    #1;
    chk("gray_w", 32'(gw), 32'(gtab[mv_w]));
    chk("bin_w",  32'(bw), 32'(mv_w));
    chk("tc_w",   32'(tw), 32'(mt_w));
    chk("gray_s", 32'(gs), 32'(gtab[mv_s]));
    chk("bin_s",  32'(bs), 32'(mv_s));
    chk("tc_s",   32'(ts), 32'(mt_s));
`ifdef GRAY_CNT_CHK_EN
    chk("err_w",  32'(err_w), 32'd0);
    chk("err_s",  32'(err_s), 32'd0);
`endif
  endtask

  initial begin
    int n;
    int pulses;
    int pulse_idx;
    gtab[0] = 0;
    gtab[1] = 1;
    n = 2;
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < n; i++) gtab[n + i] = gtab[n - 1 - i] | (1 << k);
      n = n * 2;
    end

    // Reset, then wrap-up through all 16 codes
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("rst_gray_w", 32'(gw), 32'h0);
    chk("rst_gray_s", 32'(gs), 32'h3);
    pulses = 0;
    pulse_idx = -1;
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      if (tw) begin pulses++; pulse_idx = i; end
      if (i == 15) chk("gray_at15", 32'(gw), 32'h8);
    end
    chk("tc_once", 32'(pulses), 32'd1);
    chk("tc_at_1000", 32'(pulse_idx), 32'd15);
    chk("wrapped_0", 32'(gw), 32'h0);

    // Load 0110 then count down to 0
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    chk("load_bin4", 32'(bw), 32'd4);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("down_gray0", 32'(gw), 32'h0);
    chk("down_tc", 32'(tw), 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    chk("down_wrap", 32'(bw), 32'd15);
    chk("sat_hold0", 32'(bs), 32'd0);

    // Saturate at max on the WRAP=0 instance
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      chk("sat_gray", 32'(gs), 32'h8);
      chk("sat_tc", 32'(ts), 32'd0);
    end

    // Load overrides en
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    chk("ld_ovr_gray", 32'(gw), 32'hf);
    chk("ld_ovr_bin", 32'(bw), 32'ha);

    // Reset mid-count at bin 7
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0101);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    chk("at_bin7", 32'(bw), 32'd7);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    chk("mid_rst_gray_s", 32'(gs), 32'h3);
    chk("mid_rst_tc", 32'(tw), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

`ifdef GRAY_CNT_CHK_EN
    // Deposit a 2-step jump and expect the sticky error until reset
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b0011);
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0;
    force dut_w.bin_q = 4'd5;
    @(posedge clk);
    #1;
    release dut_w.bin_q;
    repeat (2) @(posedge clk);
    #1;
    chk("err_set", 32'(err_w), 32'd1);
    @(posedge clk);
    #1;
    chk("err_sticky", 32'(err_w), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
